// File: rtl/updown_mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// updown_mod_counter_pkg
//   Shared definitions for the up/down modulo counter:
//     - DIR_UP / DIR_DOWN : encodings of the direction input
//     - params_ok()       : elaboration-time legality check of the counter
//                           parameters (width, terminal value, reset value)
// -----------------------------------------------------------------------------
package updown_mod_counter_pkg;

    // Direction encodings for the i_up input
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Returns 1 when the parameter set describes a legal counter:
    // width of at least 2 bits, terminal value representable in that width,
    // and a reset value inside the counting range.
    function automatic bit params_ok(input int width, input longint max_count,
                                     input longint reset_val);
        bit ok_v;
        ok_v = 1'b1;
        if (width < 2 || width > 62) begin
            ok_v = 1'b0;
        end else begin
            if (max_count < 64'sd0 || max_count >= (64'sd1 <<< width)) begin
                ok_v = 1'b0;
            end else begin
                ok_v = ok_v;
            end
            if (reset_val < 64'sd0 || reset_val > max_count) begin
                ok_v = 1'b0;
            end else begin
                ok_v = ok_v;
            end
        end
        return ok_v;
    endfunction

endpackage

// File: rtl/updown_mod_counter.sv
// -----------------------------------------------------------------------------
// updown_mod_counter
//   Parametrised synchronous up/down counter over the range 0..MAX_COUNT with
//   parallel load (clamped to MAX_COUNT), count enable and wrap or saturate
//   behaviour at the bounds. A bound step raises a one-cycle WRAP pulse and
//   sets a sticky OVF flag.
//
// Parameters
//   WIDTH      counter width (>=2)
//   MAX_COUNT  terminal value (<= 2**WIDTH-1)
//   RESET_VAL  value after i_clear_n / i_sclr (<= MAX_COUNT)
//   SATURATE   0 = wrap at bounds, 1 = hold at bounds
//
// Ports
//   i_clock    rising-edge clock
//   i_clear_n  asynchronous active-low clear
//   i_sclr     synchronous clear to RESET_VAL, also clears o_ovf
//   i_load     synchronous parallel load of i_d
//   i_d        load value
//   i_en       count enable
//   i_up       1 = increment, 0 = decrement
//   o_q        current count (registered)
//   o_tc       terminal count: next enabled step crosses a bound (combinational)
//   o_wrap     one-cycle pulse after a bound step (registered)
//   o_ovf      sticky overflow flag (registered)
// -----------------------------------------------------------------------------
module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 9,
    parameter int RESET_VAL = 0,
    parameter int SATURATE  = 0
) (
    input  logic             i_clock,
    input  logic             i_clear_n,
    input  logic             i_sclr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_en,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_q,
    output logic             o_tc,
    output logic             o_wrap,
    output logic             o_ovf
);

    if (!params_ok(WIDTH, longint'(MAX_COUNT), longint'(RESET_VAL))) begin : g_param_error
        $error("updown_mod_counter: illegal WIDTH/MAX_COUNT/RESET_VAL combination");
    end

    localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] C_RST  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] C_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam bit               C_SAT  = (SATURATE != 0);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_ovf;

    logic [WIDTH-1:0] w_next_q;
    logic             w_next_wrap;
    logic             w_next_ovf;
    logic             w_at_bound;

    // Bound detection: explicit compares so MAX_COUNT == 2**WIDTH-1 never
    // relies on arithmetic rollover.
    always_comb begin
        w_at_bound = 1'b0;
        if (i_up == DIR_UP) begin
            w_at_bound = (r_q == C_MAX);
        end else begin
            w_at_bound = (r_q == C_ZERO);
        end
    end

    // Next-state for count, wrap pulse and sticky flag; priority SCLR > LOAD > EN
    always_comb begin
        w_next_q    = r_q;
        w_next_wrap = 1'b0;
        w_next_ovf  = r_ovf;
        if (i_sclr) begin
            w_next_q   = C_RST;
            w_next_ovf = 1'b0;
        end else if (i_load) begin
            // Loads outside the range are clamped to the terminal value
            if (i_d > C_MAX) begin
                w_next_q = C_MAX;
            end else begin
                w_next_q = i_d;
            end
        end else if (i_en) begin
            if (w_at_bound) begin
                // Bound step: pulse and flag in both wrap and saturate modes
                w_next_wrap = 1'b1;
                w_next_ovf  = 1'b1;
                if (C_SAT) begin
                    w_next_q = r_q;
                end else if (i_up == DIR_UP) begin
                    w_next_q = C_ZERO;
                end else begin
                    w_next_q = C_MAX;
                end
            end else if (i_up == DIR_UP) begin
                w_next_q = r_q + C_ONE;
            end else begin
                w_next_q = r_q - C_ONE;
            end
        end else begin
            w_next_q = r_q;
        end
    end

    // Count, wrap pulse and overflow registers with asynchronous clear
    always_ff @(posedge i_clock or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_q    <= C_RST;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_q    <= w_next_q;
            r_wrap <= w_next_wrap;
            r_ovf  <= w_next_ovf;
        end
    end

    assign o_q    = r_q;
    assign o_wrap = r_wrap;
    assign o_ovf  = r_ovf;
    // Terminal count looks ahead at the step the current inputs would take
    assign o_tc   = i_en & ~i_sclr & ~i_load & w_at_bound;

endmodule

// File: tb/tb_updown_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_updown_mod_counter
//   Directed self-checking bench. Three instances share clock, clear and
//   control inputs: a default wrapping counter (0..9), a saturating counter
//   (0..9) and an 8-bit counter (0..255, reset value 3).
// -----------------------------------------------------------------------------
module tb_updown_mod_counter;

    logic       clk;
    logic       clear_n;
    logic       sclr;
    logic       load;
    logic [3:0] d4;
    logic [7:0] d8;
    logic       en;
    logic       up;

    logic [3:0] q_w;
    logic       tc_w, wrap_w, ovf_w;
    logic [3:0] q_s;
    logic       tc_s, wrap_s, ovf_s;
    logic [7:0] q_8;
    logic       tc_8, wrap_8, ovf_8;

    int n_total;
    int n_bad;

    updown_mod_counter #(.WIDTH(4), .MAX_COUNT(9), .RESET_VAL(0), .SATURATE(0)) u_wrap (
        .i_clock(clk), .i_clear_n(clear_n), .i_sclr(sclr), .i_load(load), .i_d(d4),
        .i_en(en), .i_up(up), .o_q(q_w), .o_tc(tc_w), .o_wrap(wrap_w), .o_ovf(ovf_w)
    );

    updown_mod_counter #(.WIDTH(4), .MAX_COUNT(9), .RESET_VAL(0), .SATURATE(1)) u_sat (
        .i_clock(clk), .i_clear_n(clear_n), .i_sclr(sclr), .i_load(load), .i_d(d4),
        .i_en(en), .i_up(up), .o_q(q_s), .o_tc(tc_s), .o_wrap(wrap_s), .o_ovf(ovf_s)
    );

    updown_mod_counter #(.WIDTH(8), .MAX_COUNT(255), .RESET_VAL(3), .SATURATE(0)) u_w8 (
        .i_clock(clk), .i_clear_n(clear_n), .i_sclr(sclr), .i_load(load), .i_d(d8),
        .i_en(en), .i_up(up), .o_q(q_8), .o_tc(tc_8), .o_wrap(wrap_8), .o_ovf(ovf_8)
    );

    // 20-unit clock
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Single comparison point: counts every check, reports mismatches
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sclr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; d4 = 4'd0; d8 = 8'd0;
    endtask

    task automatic do_sclr();
        idle_inputs();
        sclr = 1'b1;
        step();
        sclr = 1'b0;
    endtask

    int seq1 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    initial begin
        n_total = 0;
        n_bad   = 0;
        idle_inputs();
        clear_n = 1'b0;
        #25;

        // ---- Reset state
        chk("rst_q",    32'(q_w),    32'd0);
        chk("rst_wrap", 32'(wrap_w), 32'd0);
        chk("rst_ovf",  32'(ovf_w),  32'd0);
        chk("rst_q8",   32'(q_8),    32'd3);

        // ---- 1: count up 12 edges, wrap 9 -> 0
        clear_n = 1'b1;
        #2;
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t1_tc%0d", i), 32'(tc_w), (i == 9) ? 32'd1 : 32'd0);
            step();
            chk($sformatf("t1_q%0d", i),    32'(q_w),    32'(seq1[i]));
            chk($sformatf("t1_wrap%0d", i), 32'(wrap_w), (i == 9) ? 32'd1 : 32'd0);
            chk($sformatf("t1_ovf%0d", i),  32'(ovf_w),  (i >= 9) ? 32'd1 : 32'd0);
        end

        // ---- 2: saturating counter held at 0 while counting down
        do_sclr();
        load = 1'b1; d4 = 4'd1;
        step();
        chk("t2_load", 32'(q_s), 32'd1);
        load = 1'b0; en = 1'b1; up = 1'b0;
        chk("t2_tc0", 32'(tc_s), 32'd0);
        step();
        chk("t2_q1",    32'(q_s),    32'd0);
        chk("t2_wrap1", 32'(wrap_s), 32'd0);
        chk("t2_tc1",   32'(tc_s),   32'd1);
        step();
        chk("t2_q2",    32'(q_s),    32'd0);
        chk("t2_wrap2", 32'(wrap_s), 32'd1);
        chk("t2_ovf2",  32'(ovf_s),  32'd1);
        step();
        chk("t2_q3",    32'(q_s),    32'd0);
        chk("t2_wrap3", 32'(wrap_s), 32'd1);
        en = 1'b0;
        step();
        chk("t2_wrap_off", 32'(wrap_s), 32'd0);
        chk("t2_ovf_hold", 32'(ovf_s),  32'd1);
        do_sclr();
        chk("t2_sclr_q",   32'(q_s),   32'd0);
        chk("t2_sclr_ovf", 32'(ovf_s), 32'd0);

        // ---- 3: load clamp and load-over-enable
        load = 1'b1; d4 = 4'd15;
        step();
        chk("t3_clamp", 32'(q_w), 32'd9);
        d4 = 4'd5; en = 1'b1; up = 1'b1;
        chk("t3_tc_load", 32'(tc_w), 32'd0);
        step();
        chk("t3_load5", 32'(q_w),    32'd5);
        chk("t3_wrap",  32'(wrap_w), 32'd0);
        load = 1'b0; en = 1'b0;

        // ---- 4: toggle direction every edge from 4
        do_sclr();
        load = 1'b1; d4 = 4'd4;
        step();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up = (i % 2 == 0) ? 1'b1 : 1'b0;
            chk($sformatf("t4_tc%0d", i), 32'(tc_w), 32'd0);
            step();
            chk($sformatf("t4_q%0d", i),    32'(q_w),    (i % 2 == 0) ? 32'd5 : 32'd4);
            chk($sformatf("t4_wrap%0d", i), 32'(wrap_w), 32'd0);
            chk($sformatf("t4_ovf%0d", i),  32'(ovf_w),  32'd0);
        end

        // ---- 5: asynchronous clear mid-count
        idle_inputs();
        load = 1'b1; d4 = 4'd9;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        chk("t5_ovf_set", 32'(ovf_w), 32'd1);
        en = 1'b0; load = 1'b1; d4 = 4'd7;
        step();
        load = 1'b0; en = 1'b1;
        step();
        chk("t5_q8", 32'(q_w), 32'd8);
        #5;
        clear_n = 1'b0;
        #1;
        chk("t5_async_q",   32'(q_w),   32'd0);
        chk("t5_async_ovf", 32'(ovf_w), 32'd0);
        sclr = 1'b1; load = 1'b1; d4 = 4'd5;
        step();
        chk("t5_held_q", 32'(q_w), 32'd0);
        #5;
        clear_n = 1'b1;
        sclr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        chk("t5_resume", 32'(q_w), 32'd1);

        // ---- 6: 8-bit counter, reset value 3, wrap at 255
        idle_inputs();
        #5;
        clear_n = 1'b0;
        #1;
        chk("t6_rst_q8", 32'(q_8), 32'd3);
        #5;
        clear_n = 1'b1;
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 252; i++) begin
            step();
        end
        chk("t6_q255",  32'(q_8),  32'd255);
        chk("t6_tc255", 32'(tc_8), 32'd1);
        step();
        chk("t6_wrap_q",  32'(q_8),    32'd0);
        chk("t6_wrap_p",  32'(wrap_8), 32'd1);
        chk("t6_ovf",     32'(ovf_8),  32'd1);
        up = 1'b0;
        step();
        chk("t6_down_wrap", 32'(q_8), 32'd255);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
